// File: rtl/booth_seq_mul_if.sv
// booth_seq_mul_if: operand/product valid-ready bundle for booth_seq_mul
interface booth_seq_mul_if #(parameter int W = 16);
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] x, y;
  logic [2*W-1:0] p;
  modport master (output in_valid, x, y, out_ready, input in_ready, out_valid, p, busy);
  modport slave (input in_valid, x, y, out_ready, output in_ready, out_valid, p, busy);
endinterface

// File: rtl/booth_seq_mul.sv
// booth_seq_mul: sequential radix-4 Booth multiplier, one digit per cycle through booth_pp
module booth_pp #(
  parameter int W = 16,
  parameter int PIPE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   i_booth_bits,
  input  logic [W-1:0] i_y,
  output logic [W:0]   o_pp,
  output logic         o_cpl
);
  logic w_neg, w_one, w_two;
  logic [W:0] w_mag, w_pp;
  always_comb begin
    w_neg = i_booth_bits[2] & ~(i_booth_bits[1] & i_booth_bits[0]);
    w_one = i_booth_bits[1] ^ i_booth_bits[0];
    w_two = (i_booth_bits == 3'b011) | (i_booth_bits == 3'b100);
    w_mag = w_one ? {i_y[W-1], i_y} : w_two ? {i_y, 1'b0} : '0;
    w_pp  = w_neg ? ~w_mag : w_mag;
  end
  // negative digits return the one's complement; the +1 travels separately as cpl
  if (PIPE == 0) begin : g_comb
    assign o_pp  = w_pp;
    assign o_cpl = w_neg;
  end else begin : g_pipe
    logic [PIPE-1:0][W:0] r_pp;
    logic [PIPE-1:0]      r_cpl;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_pp  <= '0;
        r_cpl <= '0;
      end else begin
        r_pp[0]  <= w_pp;
        r_cpl[0] <= w_neg;
        for (int j = 1; j < PIPE; j++) begin
          r_pp[j]  <= r_pp[j-1];
          r_cpl[j] <= r_cpl[j-1];
        end
      end
    end
    assign o_pp  = r_pp[PIPE-1];
    assign o_cpl = r_cpl[PIPE-1];
  end
endmodule

module booth_seq_mul #(
  parameter int W = 16,
  parameter int PIPE = 0
) (
  input logic clk,
  input logic rst,
  booth_seq_mul_if.slave s
);
  localparam int ND = W / 2;
  localparam int KW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [KW-1:0] LAST = KW'(ND - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic [W:0] r_xs;
  logic [W-1:0] r_y;
  logic [KW-1:0] r_k, w_rk;
  logic w_iv, w_rv, w_last, w_cpl;
  logic [W:0] w_pp;
  logic [2*W-1:0] r_acc, r_p, w_term, w_acc;
  assign w_iv        = r_state == RUN;
  assign w_last      = w_rv && (w_rk == LAST);
  assign s.in_ready  = (r_state == IDLE) && !rst;
  assign s.out_valid = r_state == DONE;
  assign s.busy      = r_state != IDLE;
  assign s.p         = r_p;
  // r_xs holds {x,0} shifted right two bits per issued digit, so [2:0] is the live Booth triplet
  booth_pp #(.W(W), .PIPE(PIPE)) u_pp (
    .clk(clk), .rst(rst), .i_booth_bits(r_xs[2:0]), .i_y(r_y), .o_pp(w_pp), .o_cpl(w_cpl)
  );
  if (PIPE == 0) begin : g_nv
    assign w_rv = w_iv;
    assign w_rk = r_k;
  end else begin : g_vs
    logic [PIPE-1:0]         r_vs;
    logic [PIPE-1:0][KW-1:0] r_ks;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vs <= '0;
        r_ks <= '0;
      end else begin
        r_vs[0] <= w_iv;
        r_ks[0] <= r_k;
        for (int j = 1; j < PIPE; j++) begin
          r_vs[j] <= r_vs[j-1];
          r_ks[j] <= r_ks[j-1];
        end
      end
    end
    assign w_rv = r_vs[PIPE-1];
    assign w_rk = r_ks[PIPE-1];
  end
  assign w_term = {{(W-1){w_pp[W]}}, w_pp} + (2*W)'(w_cpl);
  assign w_acc  = r_acc + (w_term << {w_rk, 1'b0});
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = s.in_valid ? RUN : IDLE;
      RUN:     w_next = (r_k != LAST) ? RUN : (PIPE == 0) ? DONE : DRAIN;
      DRAIN:   w_next = w_last ? DONE : DRAIN;
      default: w_next = s.out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xs  <= '0;
      r_y   <= '0;
      r_k   <= '0;
      r_acc <= '0;
      r_p   <= '0;
    end else if (r_state == IDLE && s.in_valid) begin
      r_xs  <= {s.x, 1'b0};
      r_y   <= s.y;
      r_k   <= '0;
      r_acc <= '0;
    end else begin
      if (w_iv && r_k != LAST) begin
        r_xs <= r_xs >> 2;
        r_k  <= r_k + KW'(1);
      end
      if (w_rv) r_acc <= w_acc;
      if (w_last) r_p <= w_acc;
    end
  end
endmodule

// File: tb/tb_booth_seq_mul.sv
// tb_booth_seq_mul: directed W=8 vectors and corner sequences plus random W=16 regression for PIPE 0..3
module tb_booth_seq_mul;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst8, rst16;
  int n_chk = 0, n_err = 0, done_cnt = 0;
  logic go16 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  booth_seq_mul_if #(.W(8)) a();
  booth_seq_mul_if #(.W(8)) b();
  booth_seq_mul #(.W(8), .PIPE(0)) u_a (.clk(clk), .rst(rst8), .s(a));
  booth_seq_mul #(.W(8), .PIPE(2)) u_b (.clk(clk), .rst(rst8), .s(b));

  typedef struct {logic [7:0] x, y; logic [15:0] p;} vec_t;
  vec_t tv[9];

  task automatic wait_a(input logic [15:0] ep, input string nm);
    int lat = 0;
    while (!a.out_valid && lat < 50) begin
      chk({nm, " busy"}, 64'(a.busy), 64'd1);
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'd4);
    chk({nm, " p"}, 64'(a.p), 64'(ep));
  endtask

  task automatic run_a(input logic [7:0] x, input logic [7:0] y, input logic [15:0] ep, input string nm);
    @(negedge clk);
    a.in_valid = 1; a.x = x; a.y = y;
    chk({nm, " in_ready"}, 64'(a.in_ready), 64'd1);
    @(negedge clk);
    a.in_valid = 0; a.x = 8'($urandom); a.y = 8'($urandom);
    wait_a(ep, nm);
  endtask

  task automatic finish_a(input string nm);
    a.out_ready = 1;
    @(negedge clk);
    a.out_ready = 0;
    chk({nm, " idle out_valid"}, 64'(a.out_valid), 64'd0);
    chk({nm, " idle busy"}, 64'(a.busy), 64'd0);
    chk({nm, " idle in_ready"}, 64'(a.in_ready), 64'd1);
  endtask

  genvar g;
  for (g = 0; g < 4; g++) begin : g_r
    booth_seq_mul_if #(.W(16)) r();
    booth_seq_mul #(.W(16), .PIPE(g)) u (.clk(clk), .rst(rst16), .s(r));
    initial begin
      int acc_n, out_n, to;
      longint e;
      logic [31:0] ep;
      acc_n = 0; out_n = 0;
      r.in_valid = 0; r.x = 0; r.y = 0; r.out_ready = 0;
      wait (go16);
      for (int n = 0; n < 250; n++) begin
        @(negedge clk);
        r.out_ready = 0;
        r.in_valid = 1; r.x = 16'($urandom); r.y = 16'($urandom);
        to = 0;
        while (!r.in_ready && to < 40) begin @(negedge clk); to++; end
        if (to >= 40) begin chk("rand accept timeout", 64'd1, 64'd0); break; end
        e = longint'($signed(r.x)) * longint'($signed(r.y));
        ep = e[31:0];
        @(negedge clk);
        acc_n++;
        r.in_valid = 1'($urandom_range(0, 1)); r.x = 16'($urandom); r.y = 16'($urandom);
        to = 0;
        while (to < 200) begin
          r.out_ready = 1'($urandom_range(0, 1));
          if (r.out_valid && r.out_ready) break;
          @(negedge clk);
          to++;
        end
        if (to >= 200) begin chk("rand product timeout", 64'd1, 64'd0); break; end
        chk("rand p", 64'(r.p), 64'(ep));
        out_n++;
      end
      chk("rand count", 64'(out_n), 64'(acc_n));
      done_cnt++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t, prev, rises, lat;
    logic ov_prev;
    rst8 = 1; rst16 = 1;
    a.in_valid = 0; a.x = 0; a.y = 0; a.out_ready = 0;
    b.in_valid = 0; b.x = 0; b.y = 0; b.out_ready = 0;
    @(negedge clk);
    @(negedge clk);
    chk("reset in_ready", 64'(a.in_ready), 64'd0);
    chk("reset out_valid", 64'(a.out_valid), 64'd0);
    chk("reset busy", 64'(a.busy), 64'd0);
    chk("reset p", 64'(a.p), 64'd0);
    rst8 = 0; rst16 = 0;
    #1 chk("post-reset in_ready", 64'(a.in_ready), 64'd1);

    tv[0] = '{8'h03, 8'h05, 16'h000F};
    tv[1] = '{8'h80, 8'h80, 16'h4000};
    tv[2] = '{8'hFF, 8'h7F, 16'hFF81};
    tv[3] = '{8'hF9, 8'h09, 16'hFFC1};
    tv[4] = '{8'h7F, 8'h81, 16'hC0FF};
    tv[5] = '{8'h00, 8'h5A, 16'h0000};
    tv[6] = '{8'h7F, 8'h7F, 16'h3F01};
    tv[7] = '{8'h80, 8'h7F, 16'hC080};
    tv[8] = '{8'h01, 8'h80, 16'hFF80};
    for (int i = 0; i < 9; i++) begin
      run_a(tv[i].x, tv[i].y, tv[i].p, $sformatf("vec%0d", i));
      finish_a($sformatf("vec%0d", i));
    end

    run_a(8'h11, 8'h0D, 16'h00DD, "bp");
    a.in_valid = 1; a.x = 8'h02; a.y = 8'h03;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp p stable", 64'(a.p), 64'h00DD);
      chk("bp out_valid", 64'(a.out_valid), 64'd1);
      chk("bp in_ready", 64'(a.in_ready), 64'd0);
    end
    a.out_ready = 1;
    @(negedge clk);
    a.out_ready = 0;
    chk("bp release out_valid", 64'(a.out_valid), 64'd0);
    chk("bp release in_ready", 64'(a.in_ready), 64'd1);
    @(negedge clk);
    a.in_valid = 0;
    chk("bp accept busy", 64'(a.busy), 64'd1);
    wait_a(16'h0006, "bp next");
    finish_a("bp next");

    @(negedge clk);
    a.in_valid = 1; a.x = 8'h55; a.y = 8'h33;
    @(negedge clk);
    a.in_valid = 0;
    @(negedge clk);
    #2 rst8 = 1;
    #1;
    chk("midrst out_valid", 64'(a.out_valid), 64'd0);
    chk("midrst busy", 64'(a.busy), 64'd0);
    chk("midrst in_ready", 64'(a.in_ready), 64'd0);
    @(negedge clk);
    rst8 = 0;
    #1 chk("midrst release in_ready", 64'(a.in_ready), 64'd1);
    run_a(8'hF9, 8'h09, 16'hFFC1, "after rst");
    finish_a("after rst");

    @(negedge clk);
    b.in_valid = 1; b.x = 8'h7F; b.y = 8'h81;
    @(negedge clk);
    b.in_valid = 0;
    lat = 0;
    while (!b.out_valid && lat < 50) begin @(negedge clk); lat++; end
    chk("pipe2 latency", 64'(lat), 64'd6);
    chk("pipe2 p", 64'(b.p), 64'hC0FF);
    b.out_ready = 1; b.in_valid = 1; b.x = 8'h05; b.y = 8'hFD;
    t = 0; prev = -1; rises = 0; ov_prev = 1;
    while (rises < 4 && t < 100) begin
      @(negedge clk);
      t++;
      if (b.out_valid && !ov_prev) begin
        rises++;
        chk("pipe2 b2b p", 64'(b.p), 64'hFFF1);
        if (prev >= 0) chk("pipe2 b2b interval", 64'(t - prev), 64'd8);
        prev = t;
      end
      ov_prev = b.out_valid;
    end
    chk("pipe2 b2b products", 64'(rises), 64'd4);
    b.in_valid = 0;
    @(negedge clk);
    b.out_ready = 0;

    go16 = 1;
    wait (done_cnt == 4);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
